// File: rtl/pedagio_sensor_if.sv
// pedagio_sensor_if: detector inputs and classification handshake of the toll sensor
interface pedagio_sensor_if;
  logic veiculo_presente;
  logic pulso_eixo;
  logic [3:0] peso_in;
  logic [1:0] Eixos;
  logic [3:0] Peso;
  logic ready;
  logic erro;
  logic [2:0] num_eixos;
  modport master (
    input  veiculo_presente, pulso_eixo, peso_in,
    output Eixos, Peso, ready, erro, num_eixos
  );
  modport slave (
    output veiculo_presente, pulso_eixo, peso_in,
    input  Eixos, Peso, ready, erro, num_eixos
  );
endinterface

// File: rtl/pedagio_sensor.sv
// pedagio_sensor: debounced axle counting, peak weighing and ready strobe per vehicle
module pedagio_sensor #(
  parameter int DEBOUNCE = 4,
  parameter int READY_CYCLES = 8,
  parameter int TIMEOUT = 1000
) (
  input logic clk,
  input logic reset,
  pedagio_sensor_if.master bus
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] RDY_LAST = 16'(READY_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, COUNT, EVAL, READY, ERRO} state_t;
  state_t state, state_n;
  logic [DW-1:0] deb, deb_n;
  logic [2:0] cnt, cnt_n, num_n;
  logic [3:0] peak, peak_n, peso_n;
  logic [15:0] tmo, tmo_n;
  logic [1:0] eixos_n;
  logic erro_n, hit;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      deb <= '0;
      cnt <= '0;
      peak <= '0;
      tmo <= '0;
      bus.Eixos <= '0;
      bus.Peso <= '0;
      bus.num_eixos <= '0;
      bus.erro <= 1'b0;
    end else begin
      state <= state_n;
      deb <= deb_n;
      cnt <= cnt_n;
      peak <= peak_n;
      tmo <= tmo_n;
      bus.Eixos <= eixos_n;
      bus.Peso <= peso_n;
      bus.num_eixos <= num_n;
      bus.erro <= erro_n;
    end
  end
  always_comb begin
    state_n = state;
    deb_n = '0;
    cnt_n = cnt;
    peak_n = peak;
    tmo_n = tmo;
    eixos_n = bus.Eixos;
    peso_n = bus.Peso;
    num_n = bus.num_eixos;
    // debounce parks at DEB_MAX so a held treadle counts only once
    hit = state == COUNT && bus.pulso_eixo && deb == DEB_LAST;
    case (state)
      IDLE: if (bus.veiculo_presente) begin
        state_n = COUNT;
        cnt_n = '0;
        tmo_n = '0;
        peak_n = bus.peso_in;
      end
      COUNT: begin
        deb_n = bus.pulso_eixo ? (deb == DEB_MAX ? deb : deb + DW'(1)) : '0;
        cnt_n = hit && cnt != 3'd7 ? cnt + 3'd1 : cnt;
        peak_n = bus.peso_in > peak ? bus.peso_in : peak;
        tmo_n = tmo + 16'd1;
        if (!bus.veiculo_presente) begin
          state_n = EVAL;
          tmo_n = '0;
        end else if (tmo == TMO_LAST) begin
          state_n = ERRO;
          num_n = cnt_n;
        end
      end
      EVAL: begin
        num_n = cnt;
        tmo_n = '0;
        state_n = cnt < 3'd2 ? ERRO : READY;
        eixos_n = cnt < 3'd2 ? bus.Eixos : cnt >= 3'd5 ? 2'd3 : 2'(cnt - 3'd2);
        peso_n = cnt < 3'd2 ? bus.Peso : peak;
      end
      READY: begin
        tmo_n = tmo + 16'd1;
        state_n = tmo == RDY_LAST ? IDLE : READY;
      end
      ERRO: state_n = bus.veiculo_presente ? ERRO : IDLE;
      default: state_n = IDLE;
    endcase
    erro_n = state_n == ERRO && state != ERRO;
  end
  assign bus.ready = state == READY;
endmodule

// File: tb/tb_pedagio_sensor.sv
// tb_pedagio_sensor: table-driven passages plus hand sequences for timeout, retrigger and reset
module tb_pedagio_sensor;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  pedagio_sensor_if bus();
  pedagio_sensor dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int n; int hi; int peso; bit ok; int eix; int pw; int num;
  } vec_t;
  vec_t tbl[7];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic pulses(int n, int hi, int lo);
    for (int k = 0; k < n; k++) begin
      bus.pulso_eixo = 1'b1;
      repeat (hi) step();
      bus.pulso_eixo = 1'b0;
      repeat (lo) step();
    end
  endtask
  task automatic leave_and_check(string name, bit ok, int eix, int pw, int num);
    int first, rcnt, ecnt, bad;
    first = -1; rcnt = 0; ecnt = 0; bad = 0;
    bus.veiculo_presente = 1'b0;
    bus.pulso_eixo = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.ready) begin
        if (first < 0) first = i;
        rcnt++;
        if (bus.Eixos != 2'(eix) || bus.Peso != 4'(pw)) bad++;
      end
      if (bus.erro) ecnt++;
    end
    if (ok) begin
      check({name, " ready_latency"}, first, 2);
      check({name, " ready_width"}, rcnt, 8);
      check({name, " ready_data_stable"}, bad, 0);
    end else
      check({name, " ready_never"}, rcnt, 0);
    check({name, " erro_pulses"}, ecnt, ok ? 0 : 1);
    check({name, " Eixos"}, int'(bus.Eixos), eix);
    check({name, " Peso"}, int'(bus.Peso), pw);
    check({name, " num_eixos"}, int'(bus.num_eixos), num);
  endtask
  initial begin
    int first, ecnt;
    tbl[0] = '{2, 6, 5, 1'b1, 0, 5, 2};
    tbl[1] = '{3, 5, 7, 1'b1, 1, 7, 3};
    tbl[2] = '{4, 4, 9, 1'b1, 2, 9, 4};
    tbl[3] = '{6, 6, 14, 1'b1, 3, 14, 6};
    tbl[4] = '{9, 5, 2, 1'b1, 3, 2, 7};
    tbl[5] = '{1, 6, 12, 1'b0, 3, 2, 1};
    tbl[6] = '{2, 3, 13, 1'b0, 3, 2, 0};
    reset = 1'b1;
    bus.veiculo_presente = 1'b0;
    bus.pulso_eixo = 1'b0;
    bus.peso_in = 4'd0;
    step(); step();
    check("reset ready", int'(bus.ready), 0);
    check("reset erro", int'(bus.erro), 0);
    check("reset Eixos", int'(bus.Eixos), 0);
    check("reset Peso", int'(bus.Peso), 0);
    check("reset num_eixos", int'(bus.num_eixos), 0);
    reset = 1'b0;
    step();
    for (int r = 0; r < 7; r++) begin
      bus.veiculo_presente = 1'b1;
      bus.peso_in = 4'(tbl[r].peso);
      step(); step();
      pulses(tbl[r].n, tbl[r].hi, 3);
      step(); step();
      leave_and_check($sformatf("row%0d", r), tbl[r].ok, tbl[r].eix, tbl[r].pw, tbl[r].num);
    end
    // bouncing treadle then three clean axles, weight ramps 3 -> 11 -> 9
    bus.veiculo_presente = 1'b1;
    bus.peso_in = 4'd3;
    step(); step();
    for (int k = 0; k < 6; k++) pulses(1, 1 + k % 3, 2);
    bus.peso_in = 4'd11;
    pulses(2, 5, 3);
    bus.peso_in = 4'd9;
    pulses(1, 5, 3);
    leave_and_check("bounce", 1'b1, 1, 11, 3);
    // timeout: vehicle parked for 1200 cycles
    bus.veiculo_presente = 1'b1;
    bus.peso_in = 4'd6;
    first = -1; ecnt = 0;
    for (int i = 1; i <= 1200; i++) begin
      step();
      if (bus.erro) begin
        if (first < 0) first = i;
        ecnt++;
      end
      if (bus.ready) ecnt += 100;
    end
    check("timeout erro_cycle", first, 1001);
    check("timeout erro_count", ecnt, 1);
    check("timeout num_eixos", int'(bus.num_eixos), 0);
    check("timeout Peso_held", int'(bus.Peso), 11);
    bus.veiculo_presente = 1'b0;
    step(); step();
    bus.veiculo_presente = 1'b1;
    bus.peso_in = 4'd4;
    step(); step();
    pulses(2, 6, 3);
    leave_and_check("after_timeout", 1'b1, 0, 4, 2);
    // vehicle arrives during READY: its early axle is lost, new passage starts in IDLE
    bus.veiculo_presente = 1'b1;
    bus.peso_in = 4'd10;
    step(); step();
    pulses(2, 6, 3);
    bus.veiculo_presente = 1'b0;
    step(); step();
    check("retrig ready_up", int'(bus.ready), 1);
    check("retrig Eixos", int'(bus.Eixos), 0);
    bus.veiculo_presente = 1'b1;
    pulses(1, 5, 0);
    first = -1;
    for (int i = 1; i <= 12 && first < 0; i++) begin
      step();
      if (!bus.ready) first = i;
    end
    check("retrig ready_drop_seen", int'(first > 0), 1);
    pulses(3, 6, 3);
    leave_and_check("retrig", 1'b1, 1, 10, 3);
    // reset in the third READY cycle
    bus.veiculo_presente = 1'b1;
    bus.peso_in = 4'd8;
    step(); step();
    pulses(3, 6, 3);
    bus.veiculo_presente = 1'b0;
    step(); step();
    check("rst_ready cycle1", int'(bus.ready), 1);
    step(); step();
    reset = 1'b1;
    step();
    check("rst_ready ready", int'(bus.ready), 0);
    check("rst_ready Eixos", int'(bus.Eixos), 0);
    check("rst_ready Peso", int'(bus.Peso), 0);
    reset = 1'b0;
    step();
    check("rst_idle ready", int'(bus.ready), 0);
    check("rst_idle erro", int'(bus.erro), 0);
    bus.veiculo_presente = 1'b1;
    bus.peso_in = 4'd3;
    step(); step();
    pulses(2, 6, 3);
    leave_and_check("after_reset", 1'b1, 0, 3, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
